// File: rtl/veririsc_pkg.sv
// Shared definitions for the VeriRISC memory responder slice:
// opcodes, responder state encoding and wait-state limits.
package veririsc_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RD_HOLD = 2'd2,
        ST_WR_DONE = 2'd3
    } resp_state_e;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Out-of-range latencies are pulled into the legal window.
    function automatic int wait_clamp(input int w);
        if (w < WAIT_MIN) return WAIT_MIN;
        if (w > WAIT_MAX) return WAIT_MAX;
        return w;
    endfunction

endpackage

// File: rtl/veririsc_ram.sv
// Synchronous single-port RAM: registered read, write on we.
// Read data reflects the address presented at the previous edge.
module veririsc_ram #(
    parameter int AW = 5,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end

endmodule

// File: rtl/veririsc_mem_responder.sv
// Memory-side responder for the VeriRISC controller bus.
// Optional PARITY_EN: stores an even-parity bit per word, adds par_inj.
module veririsc_mem_responder
    import veririsc_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
`ifdef PARITY_EN
    input  logic          par_inj,
`endif
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic          busy,
    output logic          err
);

`ifdef PARITY_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif
    localparam logic [3:0] CNT_INIT = 4'(wait_clamp(WAIT_CYC) - 1);

    resp_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          ram_we;
    logic [RW-1:0] ram_din;
    logic [RW-1:0] ram_dout;
    logic          par_bad;
    logic          req_held;

    // Parity generation on write and checking on read.
`ifdef PARITY_EN
    assign ram_din = {(^wdata) ^ par_inj, wdata};
    assign par_bad = ^ram_dout;
`else
    assign ram_din = wdata;
    assign par_bad = 1'b0;
`endif

    assign req_held = dir_q ? mem_wr : mem_rd;

    veririsc_ram #(
        .AW (AW),
        .W  (RW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Next-state and registered-output logic for the responder FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_rd && mem_wr) begin
                    err_d = 1'b1;
                end else if (mem_rd || mem_wr) begin
                    addr_d  = addr;
                    dir_d   = mem_wr;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req_held) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    if (dir_q) begin
                        ram_we  = 1'b1;
                        state_d = ST_WR_DONE;
                    end else begin
                        rdata_d = ram_dout[DW-1:0];
                        err_d   = par_bad;
                        state_d = ST_RD_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RD_HOLD: begin
                if (mem_wr) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (!mem_rd) begin
                    state_d = ST_IDLE;
                end else if (addr != addr_q) begin
                    addr_d  = addr;
                    dir_d   = 1'b0;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_WR_DONE: begin
                if (!mem_wr) state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_veririsc_mem_responder.sv
// Bench for veririsc_mem_responder: WAIT_CYC=1 and WAIT_CYC=3 instances.
// Honours PARITY_EN when defined.
module tb_veririsc_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_s   [2];
    logic       wr_s   [2];
    logic [4:0] ad_s   [2];
    logic [7:0] wd_s   [2];
    logic       pinj_s [2];
    logic [7:0] rdata_o[2];
    logic       ready_o[2];
    logic       busy_o [2];
    logic       err_o  [2];

    logic [7:0] mdl  [2][32];
    logic       pbad [2][32];
    logic [7:0] sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    veririsc_mem_responder #(.AW(5), .DW(8), .WAIT_CYC(1)) u0 (
        .clk    (clk),
        .rst    (rst),
        .mem_rd (rd_s[0]),
        .mem_wr (wr_s[0]),
        .addr   (ad_s[0]),
        .wdata  (wd_s[0]),
`ifdef PARITY_EN
        .par_inj(pinj_s[0]),
`endif
        .rdata  (rdata_o[0]),
        .ready  (ready_o[0]),
        .busy   (busy_o[0]),
        .err    (err_o[0])
    );

    veririsc_mem_responder #(.AW(5), .DW(8), .WAIT_CYC(3)) u1 (
        .clk    (clk),
        .rst    (rst),
        .mem_rd (rd_s[1]),
        .mem_wr (wr_s[1]),
        .addr   (ad_s[1]),
        .wdata  (wd_s[1]),
`ifdef PARITY_EN
        .par_inj(pinj_s[1]),
`endif
        .rdata  (rdata_o[1]),
        .ready  (ready_o[1]),
        .busy   (busy_o[1]),
        .err    (err_o[1])
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Read access: request stays asserted on return.
    task automatic rd_access(input int i, input logic [4:0] a, input int w);
        int lat;
        int bsy;
        logic [7:0] e;
        sb.push_back(mdl[i][a]);
        rd_s[i] = 1'b1;
        wr_s[i] = 1'b0;
        ad_s[i] = a;
        lat = 0;
        bsy = 0;
        do begin
            step();
            lat++;
            if (busy_o[i]) bsy++;
        end while (!ready_o[i] && lat < 40);
        chk("rd_lat", lat, w + 1);
        chk("rd_busy_cycles", bsy, w);
        e = sb.pop_front();
        chk("rd_data", rdata_o[i], e);
        chk("rd_err", err_o[i], pbad[i][a]);
    endtask

    task automatic rd_drop(input int i);
        rd_s[i] = 1'b0;
        step();
        chk("rd_release", ready_o[i], 0);
    endtask

    task automatic wr_access(input int i, input logic [4:0] a,
                             input logic [7:0] d, input logic inj, input int w);
        int lat;
        rd_s[i]   = 1'b0;
        wr_s[i]   = 1'b1;
        ad_s[i]   = a;
        wd_s[i]   = d;
        pinj_s[i] = inj;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ready_o[i] && lat < 40);
        chk("wr_lat", lat, w + 1);
        mdl[i][a] = d;
`ifdef PARITY_EN
        pbad[i][a] = inj;
`else
        pbad[i][a] = 1'b0;
`endif
        wr_s[i]   = 1'b0;
        pinj_s[i] = 1'b0;
        step();
        chk("wr_pulse", ready_o[i], 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 2; i++) begin
            rd_s[i] = 1'b0;
            wr_s[i] = 1'b0;
            ad_s[i] = '0;
            wd_s[i] = '0;
            pinj_s[i] = 1'b0;
            for (int k = 0; k < 32; k++) pbad[i][k] = 1'b0;
        end
        rst = 1'b0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", ready_o[i], 0);
            chk("rst_busy", busy_o[i], 0);
            chk("rst_err", err_o[i], 0);
            chk("rst_rdata", rdata_o[i], 0);
        end
        rst = 1'b1;
        step();

        // Write A5 @5 with mem_wr held exactly two cycles.
        wr_s[0] = 1'b1;
        ad_s[0] = 5'd5;
        wd_s[0] = 8'hA5;
        step();
        chk("w1_busy", busy_o[0], 1);
        chk("w1_early", ready_o[0], 0);
        step();
        chk("w1_ready", ready_o[0], 1);
        chk("w1_busy_off", busy_o[0], 0);
        mdl[0][5] = 8'hA5;
        wr_s[0] = 1'b0;
        step();
        chk("w1_pulse", ready_o[0], 0);

        // Read @5 held for three ready cycles.
        rd_access(0, 5'd5, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("hold_ready", ready_o[0], 1);
            chk("hold_rdata", rdata_o[0], 8'hA5);
        end
        rd_drop(0);

        // Long-held write commits once; later wdata changes are ignored.
        wr_s[0] = 1'b1;
        ad_s[0] = 5'd9;
        wd_s[0] = 8'h11;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ready_o[0]) begin
                cnt++;
                wd_s[0] = 8'h22;
            end
        end
        chk("one_pulse", cnt, 1);
        mdl[0][9] = 8'h11;
        wr_s[0] = 1'b0;
        step();
        rd_access(0, 5'd9, 1);
        rd_drop(0);

        // Simultaneous rd and wr: err each cycle, no access.
        rd_s[0] = 1'b1;
        wr_s[0] = 1'b1;
        ad_s[0] = 5'd5;
        wd_s[0] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rw_err", err_o[0], 1);
            chk("rw_ready", ready_o[0], 0);
        end
        rd_s[0] = 1'b0;
        wr_s[0] = 1'b0;
        step();
        chk("rw_err_off", err_o[0], 0);
        rd_access(0, 5'd5, 1);
        rd_drop(0);

        // WAIT_CYC=3: read @31, then switch to @0 while held.
        wr_access(1, 5'd31, 8'h5A, 1'b0, 3);
        wr_access(1, 5'd0, 8'hC3, 1'b0, 3);
        rd_access(1, 5'd31, 3);
        rd_access(1, 5'd0, 3);
        rd_drop(1);

        // Write dropped during WAIT is not committed.
        wr_access(1, 5'd12, 8'h55, 1'b0, 3);
        wr_s[1] = 1'b1;
        ad_s[1] = 5'd12;
        wd_s[1] = 8'h77;
        step();
        wr_s[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ready_o[1]) cnt++;
        end
        chk("abort_ready", cnt, 0);
        chk("abort_busy", busy_o[1], 0);
        rd_access(1, 5'd12, 3);
        rd_drop(1);

        // Reset during WAIT of a write aborts it.
        wr_access(1, 5'd7, 8'h81, 1'b0, 3);
        wr_s[1] = 1'b1;
        ad_s[1] = 5'd7;
        wd_s[1] = 8'h3C;
        step();
        step();
        rst = 1'b0;
        step();
        chk("mid_rst_ready", ready_o[1], 0);
        chk("mid_rst_busy", busy_o[1], 0);
        chk("mid_rst_err", err_o[1], 0);
        chk("mid_rst_rdata", rdata_o[1], 0);
        rst = 1'b1;
        wr_s[1] = 1'b0;
        step();
        rd_access(1, 5'd7, 3);
        rd_drop(1);

`ifdef PARITY_EN
        // Injected parity error is reported with the read data.
        wr_access(0, 5'd2, 8'h0F, 1'b1, 1);
        rd_access(0, 5'd2, 1);
        step();
        chk("par_err_pulse", err_o[0], 0);
        rd_drop(0);
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_left observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
